audio_pwm_out: RTL and testbench
================================

Name: audio_pwm_out

Overview:
- Downstream output stage of the music path.
- Accepts 8-bit audio samples from the music synthesizer over a valid/ready handshake and buffers them in a small FIFO.
- Releases one sample per audio period (CLOCK_FREQ/AUDIO_FREQ clocks), applies volume attenuation and mute, then drives a 1-bit PWM output for the board's audio filter/amplifier.

Parameters:
- CLOCK_FREQ, 50000000, system clock frequency in Hz.
- AUDIO_FREQ, 50000, sample release rate in Hz; SAMPLE_PERIOD = CLOCK_FREQ/AUDIO_FREQ = 1000 clocks.
- FIFO_DEPTH, 4, sample buffer entries; power of two, at least 2.

Ports:
- clock  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- sample_in  input  8  unsigned audio sample; 0 = silence, 255 = full scale.
- sample_valid  input  1  sample_in is valid this cycle.
- sample_ready  output  1  FIFO can accept a sample this cycle.
- volume  input  3  attenuation as a right-shift amount, 0..7.
- mute  input  1  forces PWM duty to 0.
- pwm_out  output  1  registered PWM audio output.
- underrun  output  1  one-cycle pulse when a sample release finds the FIFO empty.
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

Behaviour:
- Reset values: pwm_out=0, underrun=0, fifo_count=0; sample_counter, pwm_count, current_sample and duty all 0. FIFO pointers cleared.
- sample_ready = !reset && (fifo_count < FIFO_DEPTH). It is combinational from registered state only, with no dependence on the same-cycle pop.
- Push: on sample_valid && sample_ready, write sample_in at the tail. The entry is visible to the pop logic on the next cycle.
- sample_counter: counts 0..SAMPLE_PERIOD-1, then wraps to 0. tick = (sample_counter == SAMPLE_PERIOD-1). The first tick is on the SAMPLE_PERIOD-th clock after reset deasserts.
- On tick with fifo_count>0:
  - pop the head;
  - current_sample <= head >> volume, using volume sampled that cycle, with zero-fill.
- On tick with fifo_count==0:
  - underrun=1 for exactly that cycle;
  - current_sample <= 0.
- Simultaneous push and pop: fifo_count is unchanged and the data order is preserved.
- Push when the FIFO is empty in the same cycle as a tick: this counts as an underrun. The pushed sample is stored and popped at the next tick.
- Pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH and never goes below 0.
- pwm_count: 8-bit free-running counter, incremented every clock, wraps 255->0.
- duty load: when pwm_count==255, duty <= mute ? 0 : current_sample. This is the only point at which duty changes, so the PWM never glitches mid-carrier.
- Output: every clock, pwm_out <= (pwm_count < duty).
  - duty=0 gives pwm_out constantly low.
  - duty=D gives pwm_out high for D of every 256 clocks.
- Latency: a sample pushed into an empty FIFO appears on pwm_out at the first tick after the push, plus the wait to the next pwm_count==255, plus 1 clock for the output register.
- mute does not stop FIFO draining; samples are consumed and discarded as normal.
- Reset mid-operation: FIFO contents are discarded, all counters restart from 0, and pwm_out goes low on the next clock.

Optional Feature:
- Macro UNDERRUN_HOLD_EN.
- Defined: on an underrun tick, current_sample keeps its previous value (hold last sample). The underrun pulse still fires.
- Undefined: on an underrun tick, current_sample <= 0 (silence), as described in Behaviour.

Test Plan:
- Reset release with no pushes -> underrun pulses at clock 1000, 2000 and 3000 after reset deassertion; pwm_out stays 0; fifo_count stays 0.
- Push 5 samples on back-to-back cycles -> 4 accepted, sample_ready low on the 5th cycle, fifo_count=4. After the next tick, fifo_count=3 and sample_ready=1.
- Push 0x80 with volume=0 before the first tick -> after the next duty load, pwm_out is high for exactly 128 of each 256 clocks.
- Push 0xFF with volume=2 -> duty=63; pwm_out is high 63 clocks per carrier period. The same test with volume=7 gives duty=1.
- Push 0xC0 with mute=1 -> fifo_count drains to 0 at the tick and pwm_out stays 0. Deassert mute with 0xC0 still the current sample -> 192/256 duty after the next pwm_count==255.
- Reset asserted mid-stream with 3 samples queued -> the next cycle shows fifo_count=0, pwm_out=0, sample_ready=0. After release, the first underrun occurs 1000 clocks later (or the last sample is held, if UNDERRUN_HOLD_EN is defined and the sample value is cleared by reset to 0).

Source files
------------

// File: rtl/audio_pwm_out_if.sv
// Sample handshake between the music synthesizer (master) and audio_pwm_out (slave).
interface audio_pwm_out_if;
   logic [7:0] sample_in;
   logic       sample_valid;
   logic       sample_ready;

   modport master (output sample_in, output sample_valid, input sample_ready);
   modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/audio_pwm_out.sv
// Audio output stage: sample FIFO, per-period release with volume/mute, 8-bit PWM.
// Define UNDERRUN_HOLD_EN to hold the last sample on underrun instead of emitting silence.
module audio_pwm_out #(
   parameter int unsigned CLOCK_FREQ = 50000000,
   parameter int unsigned AUDIO_FREQ = 50000,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                          clock,
   input  logic                          reset,
   audio_pwm_out_if.slave                snk,
   input  logic [2:0]                    volume,
   input  logic                          mute,
   output logic                          pwm_out,
   output logic                          underrun,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
   localparam int unsigned SAMPLE_PERIOD = CLOCK_FREQ / AUDIO_FREQ;
   localparam int unsigned CW            = $clog2(SAMPLE_PERIOD);
   localparam int unsigned AW            = $clog2(FIFO_DEPTH);

   logic [CW-1:0] sample_cnt_q, sample_cnt_d;
   logic [7:0]    pwm_cnt_q, pwm_cnt_d;
   logic [7:0]    cur_q, cur_d;
   logic [7:0]    duty_q, duty_d;
   logic          pwm_q, pwm_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic [7:0]    mem_q [FIFO_DEPTH];

   logic tick, push, pop, ready;

   always_comb begin
      tick  = (sample_cnt_q == CW'(SAMPLE_PERIOD - 1));
      ready = !reset && (count_q < (AW+1)'(FIFO_DEPTH));
      push  = snk.sample_valid && ready;
      pop   = tick && (count_q != '0);

      sample_cnt_d = tick ? '0 : sample_cnt_q + 1'b1;
      pwm_cnt_d    = pwm_cnt_q + 1'b1;
      wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d     = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      cur_d = cur_q;
      if (pop) begin
         cur_d = mem_q[rd_ptr_q] >> volume;
      end else if (tick) begin
`ifdef UNDERRUN_HOLD_EN
         cur_d = cur_q;
`else
         cur_d = '0;
`endif
      end

      // Duty only changes at the carrier boundary so a period is never cut short.
      duty_d = (pwm_cnt_q == 8'hFF) ? (mute ? '0 : cur_q) : duty_q;
      pwm_d  = (pwm_cnt_q < duty_q);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sample_cnt_q <= '0;
         pwm_cnt_q    <= '0;
         cur_q        <= '0;
         duty_q       <= '0;
         pwm_q        <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
      end else begin
         sample_cnt_q <= sample_cnt_d;
         pwm_cnt_q    <= pwm_cnt_d;
         cur_q        <= cur_d;
         duty_q       <= duty_d;
         pwm_q        <= pwm_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         mem_q[wr_ptr_q] <= snk.sample_in;
      end
   end

   assign snk.sample_ready = ready;
   assign underrun         = !reset && tick && (count_q == '0);
   assign pwm_out          = pwm_q;
   assign fifo_count       = count_q;
endmodule

// File: tb/tb_audio_pwm_out.sv
// Directed bench for audio_pwm_out with default parameters (1000-clock sample period).
module tb_audio_pwm_out;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] volume = 3'd0;
   logic       mute = 1'b0;
   logic       pwm_out;
   logic       underrun;
   logic [2:0] fifo_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   audio_pwm_out_if bus ();

   audio_pwm_out #(.CLOCK_FREQ(50000000), .AUDIO_FREQ(50000), .FIFO_DEPTH(4)) dut (
      .clock      (clock),
      .reset      (reset),
      .snk        (bus.slave),
      .volume     (volume),
      .mute       (mute),
      .pwm_out    (pwm_out),
      .underrun   (underrun),
      .fifo_count (fifo_count)
   );

   always #5 clock = ~clock;

   // Clocks since the last reset edge; equals the sample-period phase.
   always @(posedge clock) cyc <= reset ? 0 : cyc + 1;

   task automatic wait_until(input int n);
      int guard = 0;
      while (cyc != n && guard < 20000) begin
         @(negedge clock);
         guard++;
      end
      if (cyc != n) begin
         tests++; fails++;
         $display("FAIL wait_until: cyc=%0d required %0d", cyc, n);
      end
   endtask

   task automatic do_reset();
      bus.sample_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic push(input logic [7:0] d);
      bus.sample_in    = d;
      bus.sample_valid = 1'b1;
      @(negedge clock);
      bus.sample_valid = 1'b0;
   endtask

   task automatic measure(input int start, output int ones);
      wait_until(start);
      ones = 0;
      for (int i = 0; i < 256; i++) begin
         ones += int'(pwm_out);
         @(negedge clock);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.sample_valid = 1'b0;
      repeat (2) @(negedge clock);
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
      tests++; if (pwm_out !== 1'b0) begin fails++; $display("FAIL rst_pwm: got %b want 0", pwm_out); end
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL rst_underrun: got %b want 0", underrun); end
      tests++; if (bus.sample_ready !== 1'b0) begin fails++; $display("FAIL rst_ready: got %b want 0", bus.sample_ready); end
      reset = 1'b0;
      for (int k = 1; k <= 3; k++) begin
         wait_until(k * 1000 - 2);
         tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL idle_pre_tick%0d: underrun %b want 0", k, underrun); end
         @(negedge clock);
         tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL idle_tick%0d: underrun %b want 1", k, underrun); end
         tests++; if (pwm_out !== 1'b0 || fifo_count !== 3'd0) begin
            fails++; $display("FAIL idle_state%0d: pwm %b count %0d want 0 0", k, pwm_out, fifo_count);
         end
      end
   endtask

   task automatic test_back_to_back();
      int ones;
      do_reset();
      volume = 3'd0;
      wait_until(10);
      for (int i = 0; i < 5; i++) begin
         bus.sample_in    = 8'(i + 1);
         bus.sample_valid = 1'b1;
         tests++; if (bus.sample_ready !== (i < 4)) begin
            fails++; $display("FAIL b2b_ready%0d: got %b want %b", i, bus.sample_ready, (i < 4));
         end
         @(negedge clock);
      end
      bus.sample_valid = 1'b0;
      tests++; if (fifo_count !== 3'd4) begin fails++; $display("FAIL b2b_full: got %0d want 4", fifo_count); end
      wait_until(1000);
      tests++; if (fifo_count !== 3'd3 || bus.sample_ready !== 1'b1) begin
         fails++; $display("FAIL b2b_after_tick: count %0d ready %b want 3 1", fifo_count, bus.sample_ready);
      end
      // Push during a tick while popping: count must not move.
      wait_until(1999);
      bus.sample_in    = 8'h55;
      bus.sample_valid = 1'b1;
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL b2b_no_underrun: got %b want 0", underrun); end
      @(negedge clock);
      bus.sample_valid = 1'b0;
      tests++; if (fifo_count !== 3'd3) begin fails++; $display("FAIL pushpop_count: got %0d want 3", fifo_count); end
      measure(2100, ones);
      tests++; if (ones !== 2) begin fails++; $display("FAIL order_second: high %0d want 2", ones); end
      measure(5100, ones);
      tests++; if (ones !== 85) begin fails++; $display("FAIL order_last: high %0d want 85", ones); end
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL drained: got %0d want 0", fifo_count); end
   endtask

   task automatic test_pwm_half();
      int ones;
      do_reset();
      volume = 3'd0;
      wait_until(5);
      push(8'h80);
      wait_until(999);
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL half_underrun: got %b want 0", underrun); end
      measure(1100, ones);
      tests++; if (ones !== 128) begin fails++; $display("FAIL half_duty: high %0d want 128", ones); end
   endtask

   task automatic test_volume();
      int ones;
      do_reset();
      volume = 3'd2;
      wait_until(5);
      push(8'hFF);
      measure(1100, ones);
      tests++; if (ones !== 63) begin fails++; $display("FAIL vol2_duty: high %0d want 63", ones); end
      do_reset();
      volume = 3'd7;
      wait_until(5);
      push(8'hFF);
      measure(1100, ones);
      tests++; if (ones !== 1) begin fails++; $display("FAIL vol7_duty: high %0d want 1", ones); end
      volume = 3'd0;
   endtask

   task automatic test_mute();
      int ones;
      do_reset();
      volume = 3'd0;
      mute = 1'b1;
      wait_until(5);
      push(8'hC0);
      wait_until(1000);
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL mute_drain: got %0d want 0", fifo_count); end
      measure(1100, ones);
      tests++; if (ones !== 0) begin fails++; $display("FAIL mute_duty: high %0d want 0", ones); end
      mute = 1'b0;
      measure(1600, ones);
      tests++; if (ones !== 192) begin fails++; $display("FAIL unmute_duty: high %0d want 192", ones); end
   endtask

   task automatic test_push_on_tick();
      int ones;
      do_reset();
      volume = 3'd0;
      wait_until(999);
      bus.sample_in    = 8'h40;
      bus.sample_valid = 1'b1;
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL tickpush_underrun: got %b want 1", underrun); end
      @(negedge clock);
      bus.sample_valid = 1'b0;
      tests++; if (fifo_count !== 3'd1) begin fails++; $display("FAIL tickpush_stored: got %0d want 1", fifo_count); end
      wait_until(2000);
      tests++; if (fifo_count !== 3'd0) begin fails++; $display("FAIL tickpush_pop: got %0d want 0", fifo_count); end
      measure(2100, ones);
      tests++; if (ones !== 64) begin fails++; $display("FAIL tickpush_duty: high %0d want 64", ones); end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      volume = 3'd0;
      wait_until(5);
      push(8'hFF);
      wait_until(1100);
      push(8'h11);
      push(8'h22);
      push(8'h33);
      tests++; if (fifo_count !== 3'd3 || pwm_out !== 1'b1) begin
         fails++; $display("FAIL mid_pre: count %0d pwm %b want 3 1", fifo_count, pwm_out);
      end
      reset = 1'b1;
      @(negedge clock);
      tests++; if (fifo_count !== 3'd0 || pwm_out !== 1'b0 || bus.sample_ready !== 1'b0) begin
         fails++; $display("FAIL mid_reset: count %0d pwm %b ready %b want 0 0 0", fifo_count, pwm_out, bus.sample_ready);
      end
      reset = 1'b0;
      wait_until(998);
      tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL mid_pre_tick: underrun %b want 0", underrun); end
      @(negedge clock);
      tests++; if (underrun !== 1'b1) begin fails++; $display("FAIL mid_first_tick: underrun %b want 1", underrun); end
   endtask

   initial begin
      bus.sample_in    = 8'h00;
      bus.sample_valid = 1'b0;
      @(negedge clock);
      test_reset();
      test_back_to_back();
      test_pwm_half();
      test_volume();
      test_mute();
      test_push_on_tick();
      test_reset_midstream();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
